// File: rtl/mod_frame_ctrl.sv
// Frame controller: preamble / payload / gap symbol framing with a two-nibble payload buffer.
// Optional payload scrambler (x^7+x^6+1) is built only when MOD_FRAME_SCRAMBLE_EN is defined.
module mod_frame_ctrl #(
    parameter int PREAMBLE_LEN = 8,
    parameter int PAYLOAD_LEN  = 64,
    parameter int GAP_LEN      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       bit_ready,
    output logic [3:0] sym_out,
    output logic       sym_valid,
    output logic       sym_first,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    localparam int MAX_PL  = (PREAMBLE_LEN > PAYLOAD_LEN) ? PREAMBLE_LEN : PAYLOAD_LEN;
    localparam int MAX_LEN = (MAX_PL > GAP_LEN) ? MAX_PL : GAP_LEN;
    localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [CW-1:0] P_LAST = CW'(PREAMBLE_LEN - 1);
    localparam logic [CW-1:0] L_LAST = CW'(PAYLOAD_LEN - 1);
    localparam logic [CW-1:0] G_LAST = CW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, GAP} state_t;

    state_t        state, state_nx;
    logic [1:0]    phase;
    logic [CW-1:0] cnt;
    logic          tick, pay_tick, enter_idle, accept_start;

    logic [3:0] asm_q, stg_q, sym_q, sym_nx;
    logic [2:0] acnt;
    logic       stg_full;
    logic       accept, consume, nib_done, slot_free, move;
    logic [3:0] asm_shift, nib_val, pay_raw, pay_sym;

    assign tick         = (state != IDLE) && (phase == 2'd3);
    assign pay_tick     = tick && (state == PAYLOAD);
    assign enter_idle   = (state != IDLE) && (state_nx == IDLE);
    assign accept_start = (state == IDLE) && start;

    // State register: phase and per-state symbol count restart on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            phase <= 2'd0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            phase <= (state == IDLE) ? 2'd0 : phase + 2'd1;
            if (state_nx != state)
                cnt <= '0;
            else if (tick)
                cnt <= cnt + CW'(1);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (start) state_nx = PREAMBLE;
            PREAMBLE: if (tick && cnt == P_LAST) state_nx = PAYLOAD;
            PAYLOAD:  if (tick && cnt == L_LAST) state_nx = (GAP_LEN == 0) ? IDLE : GAP;
            GAP:      if (tick && cnt == G_LAST) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        sym_valid = tick && (state != GAP);
        sym_first = tick && (state == PREAMBLE) && (cnt == '0);
        bit_ready = ((state == PREAMBLE) || (state == PAYLOAD)) && ((acnt < 3'd4) || !stg_full);
        case (state)
            PREAMBLE: sym_nx = cnt[0] ? 4'b1100 : 4'b0011;
            PAYLOAD:  sym_nx = pay_sym;
            default:  sym_nx = sym_q;
        endcase
        sym_out = sym_valid ? sym_nx : sym_q;
    end

    // A nibble may complete and take the staging slot in the same cycle a tick frees it.
    assign accept    = bit_valid && bit_ready;
    assign asm_shift = {asm_q[2:0], bit_in};
    assign consume   = pay_tick && stg_full;
    assign nib_done  = (acnt == 3'd4) || ((acnt == 3'd3) && accept);
    assign nib_val   = accept ? asm_shift : asm_q;
    assign slot_free = !stg_full || consume;
    assign move      = nib_done && slot_free;
    assign pay_raw   = stg_full ? stg_q : 4'b0000;

`ifdef MOD_FRAME_SCRAMBLE_EN
    logic [6:0] lfsr, lfsr_nx;
    logic [3:0] mask;

    always_comb begin
        lfsr_nx = lfsr;
        mask    = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            mask[3-i] = lfsr_nx[6] ^ lfsr_nx[5];
            lfsr_nx   = {lfsr_nx[5:0], lfsr_nx[6] ^ lfsr_nx[5]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || accept_start)
            lfsr <= 7'h7F;
        else if (pay_tick)
            lfsr <= lfsr_nx;
    end

    assign pay_sym = pay_raw ^ mask;
`else
    assign pay_sym = pay_raw;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q      <= 4'b0000;
            acnt       <= 3'd0;
            stg_q      <= 4'b0000;
            stg_full   <= 1'b0;
            sym_q      <= 4'b0000;
            underrun   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= enter_idle;
            if (sym_valid)
                sym_q <= sym_nx;
            if (accept_start)
                underrun <= 1'b0;
            else if (pay_tick && !stg_full)
                underrun <= 1'b1;
            if (accept_start || enter_idle) begin
                asm_q    <= 4'b0000;
                acnt     <= 3'd0;
                stg_q    <= 4'b0000;
                stg_full <= 1'b0;
            end else if (move) begin
                stg_q    <= nib_val;
                stg_full <= 1'b1;
                asm_q    <= 4'b0000;
                acnt     <= 3'd0;
            end else begin
                if (accept) begin
                    asm_q <= asm_shift;
                    acnt  <= acnt + 3'd1;
                end
                if (consume)
                    stg_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mod_frame_ctrl.sv
// Bench for mod_frame_ctrl: two configurations (8/64/4 and 2/1/0) driven by shared stimulus,
// each checked every cycle against a frame-timeline/queue model, plus literal spot checks.
module tb_mod_frame_ctrl;

    logic clk = 1'b0;
    logic rst, start, bit_in, bit_valid;
    logic       rdy [2];
    logic [3:0] sym [2];
    logic       vld [2];
    logic       fst [2];
    logic       bsy [2];
    logic       dne [2];
    logic       urn [2];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int acc    = 0;
    bit acc_flag  = 1'b0;
    bit zero_mode = 1'b0;

    initial forever #5 clk = ~clk;

    task automatic chk(input int id, input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d.%s cycle %0d: got %0h expected %0h", id, nm, cyc, act, exp);
        end
    endtask

    // Bit source: 1010... indexed by the number of bits dut0 has accepted this frame.
    initial forever begin
        @(negedge clk);
        acc_flag = bit_valid && rdy[0];
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (acc_flag) acc++;
        bit_in = zero_mode ? 1'b0 : ((acc % 2) == 0);
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic frame_start();
        start  = 1'b1;
        acc    = 0;
        bit_in = zero_mode ? 1'b0 : 1'b1;
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int P = (g == 0) ? 8 : 2;
        localparam int L = (g == 0) ? 64 : 1;
        localparam int G = (g == 0) ? 4 : 0;
        localparam int N = P + L + G;

        mod_frame_ctrl #(.PREAMBLE_LEN(P), .PAYLOAD_LEN(L), .GAP_LEN(G)) u_dut (
            .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
            .bit_ready(rdy[g]), .sym_out(sym[g]), .sym_valid(vld[g]), .sym_first(fst[g]),
            .busy(bsy[g]), .frame_done(dne[g]), .underrun(urn[g]));

        // Model: frame position d = cycles since the accepted start; bits held in a queue.
        initial begin
            bit         active;
            int         t0, d, k;
            bit         q[$];
            bit         m_urun, tk, ev, ef, eb, ed, er, uevt;
            logic [3:0] m_last, nib;
            logic [6:0] m_lfsr;
            active = 1'b0; t0 = 0; m_urun = 1'b0; m_last = 4'h0; m_lfsr = 7'h7F;
            forever begin
                @(negedge clk);
                d    = active ? cyc - t0 : -1;
                eb   = active && d >= 1 && d <= 4 * N;
                tk   = eb && (d % 4) == 0;
                k    = d / 4;
                ev   = tk && k <= P + L;
                ef   = tk && k == 1;
                ed   = active && d == 4 * N + 1;
                er   = active && d >= 1 && d <= 4 * (P + L) && q.size() < 8;
                uevt = 1'b0;
                nib  = m_last;
                if (tk && k <= P) begin
                    nib = (k % 2 == 1) ? 4'h3 : 4'hC;
                end else if (ev) begin
                    if (q.size() >= 4) begin
                        nib = {q[0], q[1], q[2], q[3]};
                        for (int i = 0; i < 4; i++) void'(q.pop_front());
                    end else begin
                        nib  = 4'h0;
                        uevt = 1'b1;
                    end
`ifdef MOD_FRAME_SCRAMBLE_EN
                    for (int i = 0; i < 4; i++) begin
                        bit b;
                        b = m_lfsr[6] ^ m_lfsr[5];
                        nib[3-i] = nib[3-i] ^ b;
                        m_lfsr = {m_lfsr[5:0], b};
                    end
`endif
                end
                if (cyc >= 1) begin
                    chk(g, "sym_out",    8'(sym[g]), 8'(ev ? nib : m_last));
                    chk(g, "sym_valid",  8'(vld[g]), 8'(ev));
                    chk(g, "sym_first",  8'(fst[g]), 8'(ef));
                    chk(g, "busy",       8'(bsy[g]), 8'(eb));
                    chk(g, "frame_done", 8'(dne[g]), 8'(ed));
                    chk(g, "underrun",   8'(urn[g]), 8'(m_urun));
                    chk(g, "bit_ready",  8'(rdy[g]), 8'(er));
                end
                if (rst) begin
                    active = 1'b0; q.delete(); m_urun = 1'b0; m_last = 4'h0; m_lfsr = 7'h7F;
                end else begin
                    if (ev) m_last = nib;
                    if (uevt) m_urun = 1'b1;
                    if (er && bit_valid) q.push_back(bit_in);
                    if (ed) begin active = 1'b0; q.delete(); end
                    if (start && !active) begin
                        active = 1'b1; t0 = cyc; m_urun = 1'b0; q.delete(); m_lfsr = 7'h7F;
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        run_to(2);
        chk(0, "rst.busy", 8'(bsy[0]), 8'h0);
        chk(0, "rst.sym_out", 8'(sym[0]), 8'h0);
        chk(0, "rst.bit_ready", 8'(rdy[0]), 8'h0);
        run_to(3); rst = 1'b0;

        // Frame 1: start at cycle 10, continuous 1010 supply.
        run_to(10); frame_start(); bit_valid = 1'b1;
        step(); start = 1'b0;
        chk(0, "f1.busy@11", 8'(bsy[0]), 8'h1);
        run_to(13); chk(0, "f1.valid@13", 8'(vld[0]), 8'h0);
        run_to(14);
        chk(0, "f1.valid@14", 8'(vld[0]), 8'h1);
        chk(0, "f1.first@14", 8'(fst[0]), 8'h1);
        chk(0, "f1.sym@14", 8'(sym[0]), 8'h3);
        run_to(15);
        chk(0, "f1.hold@15", 8'(sym[0]), 8'h3);
        start = 1'b1;
        step(); start = 1'b0;
        run_to(18);
        chk(0, "f1.sym@18", 8'(sym[0]), 8'hC);
        chk(0, "f1.first@18", 8'(fst[0]), 8'h0);
        run_to(22); chk(1, "b.valid@22", 8'(vld[1]), 8'h1);
        run_to(23);
        chk(1, "b.done@23", 8'(dne[1]), 8'h1);
        chk(1, "b.busy@23", 8'(bsy[1]), 8'h0);
        run_to(24); chk(1, "b.busy@24", 8'(bsy[1]), 8'h0);
        run_to(46); chk(0, "f1.pay1", 8'(sym[0]), 8'hA);
        run_to(298);
        chk(0, "f1.pay64", 8'(sym[0]), 8'hA);
        chk(0, "f1.pay64v", 8'(vld[0]), 8'h1);
        run_to(314); chk(0, "f1.done@314", 8'(dne[0]), 8'h0);
        run_to(315);
        chk(0, "f1.done@315", 8'(dne[0]), 8'h1);
        chk(0, "f1.underrun", 8'(urn[0]), 8'h0);

        // Frame 2: supply gap makes payload symbols 5 and 6 underrun.
        run_to(330); frame_start();
        step(); start = 1'b0;
        run_to(375); bit_valid = 1'b0;
        run_to(378); chk(0, "f2.sym4", 8'(sym[0]), 8'hA);
        run_to(382);
        chk(0, "f2.sym5", 8'(sym[0]), 8'h0);
        chk(0, "f2.sym5v", 8'(vld[0]), 8'h1);
        run_to(383); chk(0, "f2.urun@383", 8'(urn[0]), 8'h1);
        run_to(386); bit_valid = 1'b1; chk(0, "f2.sym6", 8'(sym[0]), 8'h0);
        run_to(390); chk(0, "f2.sym7", 8'(sym[0]), 8'hA);
        run_to(635);
        chk(0, "f2.done", 8'(dne[0]), 8'h1);
        chk(0, "f2.urun@end", 8'(urn[0]), 8'h1);
        run_to(650); frame_start();
        step(); start = 1'b0;
        chk(0, "f3.urun_clr", 8'(urn[0]), 8'h0);

        // Frame 3: underrun, then rst at the 20th payload symbol.
        run_to(700); bit_valid = 1'b0;
        run_to(721); bit_valid = 1'b1;
        run_to(762);
        chk(0, "f3.valid@762", 8'(vld[0]), 8'h1);
        chk(0, "f3.urun@762", 8'(urn[0]), 8'h1);
        rst = 1'b1;
        step(); rst = 1'b0;
        chk(0, "rst.sym", 8'(sym[0]), 8'h0);
        chk(0, "rst.busy2", 8'(bsy[0]), 8'h0);
        chk(0, "rst.urun", 8'(urn[0]), 8'h0);
        for (int i = 0; i < 8; i++) begin
            chk(0, "rst.no_done", 8'(dne[0]), 8'h0);
            step();
        end
        run_to(780); frame_start();
        step(); start = 1'b0;
        run_to(784);
        chk(0, "f4.first", 8'(fst[0]), 8'h1);
        chk(0, "f4.sym", 8'(sym[0]), 8'h3);
        run_to(1085); chk(0, "f4.done", 8'(dne[0]), 8'h1);

`ifdef MOD_FRAME_SCRAMBLE_EN
        // Frame 5: all-zero payload exposes the scrambler sequence.
        run_to(1100); zero_mode = 1'b1; frame_start();
        step(); start = 1'b0;
        run_to(1104); chk(0, "scr.pre", 8'(sym[0]), 8'h3);
        run_to(1136); chk(0, "scr.pay1", 8'(sym[0]), 8'h0);
        run_to(1140); chk(0, "scr.pay2", 8'(sym[0]), 8'h2);
        run_to(1420);
`else
        run_to(1100);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
